// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the TinyRisc-V multi-cycle sequencer: state encoding,
// major opcodes, trap cause codes and the legal-opcode decoder.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;

    function automatic logic is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM, OP_FENCE: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/core_ctrl_bus_watchdog.sv
// Bus request watchdog: counts unacknowledged wait cycles since the last start
// and flags the cycle on which the count reaches BUS_TIMEOUT (0 disables it).
module bus_watchdog #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bus_wait,
    output logic expired
);
    localparam int CW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(BUS_TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
    localparam bit EN = (BUS_TIMEOUT > 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a stuck request never wraps back to a safe count.
    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = '0;
        else if (bus_wait && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // An ack clears bus_wait, so an ack on the expiry cycle wins.
    assign expired = EN && bus_wait && (cnt_q >= LAST);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with trap handling and bus
// watchdog. Define CORE_CTRL_PERF_EN to add the cycle/instret counters.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        wb_reg,
    input  logic        csr_wb,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        csr_we,
    output logic        trap,
    output logic [3:0]  trap_cause,
    output logic [2:0]  state
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    state_e     state_q, state_d;
    logic [3:0] cause_q, cause_d;
    logic       wd_start, wd_wait, wd_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (wd_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IFETCH_FAULT;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC:   state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d = ST_TRAP;
                    cause_d = (opcode == OP_STORE) ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_FETCH;
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        csr_we     = 1'b0;
        trap       = 1'b0;
        trap_cause = '0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
            end
            ST_WB: begin
                pc_we  = 1'b1;
                reg_we = wb_reg && (opcode != OP_FENCE);
                csr_we = csr_wb && (opcode == OP_SYSTEM);
            end
            ST_TRAP: begin
                pc_we      = 1'b1;
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: ;
        endcase
    end

    assign state = state_q;

    // Restart the count on every entry into a bus-request state.
    assign wd_start = (state_d == ST_FETCH || state_d == ST_MEM) && (state_d != state_q);
    assign wd_wait  = (state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack);

    bus_watchdog #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .start    (wd_start),
        .bus_wait (wd_wait),
        .expired  (wd_expired)
    );

`ifdef CORE_CTRL_PERF_EN
    logic [63:0] cycle_q, cycle_d, instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q + ((state_q == ST_WB) ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: a cycle-list reference model per
// instruction, random opcodes/bus delays/stray acks, and directed corner cases.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic        wb_reg = 1'b0, csr_wb = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, csr_we, trap;
    logic [3:0]  trap_cause;
    logic [2:0]  state;
`ifdef CORE_CTRL_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    core_ctrl #(.BUS_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .wb_reg(wb_reg), .csr_wb(csr_wb),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .csr_we(csr_we),
        .trap(trap), .trap_cause(trap_cause), .state(state)
`ifdef CORE_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, csr_we, trap;
        logic [3:0] cause;
        logic [2:0] st;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    logic [6:0] legal_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                   7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                   7'b0110011, 7'b1110011, 7'b0001111};

    function automatic bit legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, csr_we, trap, trap_cause, state};
        return o;
    endfunction

    function automatic obs_t trap_cyc(input logic [3:0] cause);
        obs_t e = '0;
        e.st = ST_TRAP; e.pc_we = 1'b1; e.trap = 1'b1; e.cause = cause;
        return e;
    endfunction

    // One clock: drive acks at the falling edge, sample just after, record.
    task automatic cyc(input logic ia, input logic da, input obs_t e);
        @(negedge clk);
        imem_ack = ia;
        dmem_ack = da;
        #1;
        exp_q.push_back(e);
        obs_q.push_back(sample());
    endtask

    // Reference: expected per-cycle outputs of one instruction, from FETCH up to
    // its WB or TRAP cycle. A delay >= T means the ack never comes in time.
    task automatic run_instr(input logic [6:0] op, input logic wbr, input logic csrw,
                             input int fdly, input int mdly);
        obs_t e;
        bit   is_st;
        opcode = op; wb_reg = wbr; csr_wb = csrw;
        for (int c = 0; c < T; c++) begin
            e = '0; e.st = ST_FETCH; e.imem_req = 1'b1;
            if (c == fdly) begin
                e.ir_we = 1'b1;
                cyc(1'b1, 1'($urandom_range(0, 1)), e);
                break;
            end
            cyc(1'b0, 1'($urandom_range(0, 1)), e);
            if (c == T - 1) begin
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), trap_cyc(4'd1));
                return;
            end
        end
        e = '0; e.st = ST_DECODE;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
        if (!legal(op)) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), trap_cyc(4'd2));
            return;
        end
        e = '0; e.st = ST_EXEC;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            is_st = (op == 7'b0100011);
            for (int c = 0; c < T; c++) begin
                e = '0; e.st = ST_MEM; e.dmem_req = 1'b1; e.dmem_we = is_st;
                if (c == mdly) begin
                    cyc(1'($urandom_range(0, 1)), 1'b1, e);
                    break;
                end
                cyc(1'($urandom_range(0, 1)), 1'b0, e);
                if (c == T - 1) begin
                    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        trap_cyc(is_st ? 4'd7 : 4'd5));
                    return;
                end
            end
        end
        e = '0; e.st = ST_WB; e.pc_we = 1'b1;
        e.reg_we = wbr && (op != 7'b0001111);
        e.csr_we = csrw && (op == 7'b1110011);
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            o = sample();
            checks++;
            if (o !== obs_t'(0)) begin
                errors++; $display("FAIL reset_hold: got %h want %h", o, obs_t'(0));
            end
        end
`ifdef CORE_CTRL_PERF_EN
        checks++;
        if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0; #1;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++; $display("FAIL reset_exit: got %h want %h", o, obs_t'(0));
        end
    endtask

    task automatic test_addi();
        exp_q.delete(); obs_q.delete();
        run_instr(7'b0010011, 1'b1, 1'b0, 0, 0);
        run_instr(7'b0110011, 1'b1, 1'b0, 2, 0);
        run_instr(7'b1110011, 1'b1, 1'b1, 0, 0);
        run_instr(7'b0001111, 1'b1, 1'b1, 1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL alu cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_load_delay();
        exp_q.delete(); obs_q.delete();
        run_instr(7'b0000011, 1'b1, 1'b0, 0, 3);
        run_instr(7'b0100011, 1'b0, 1'b0, 0, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL load_store cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        exp_q.delete(); obs_q.delete();
        run_instr(7'b0000000, 1'b1, 1'b1, 0, 0);
        run_instr(7'b1111111, 1'b1, 1'b1, 1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL illegal cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        exp_q.delete(); obs_q.delete();
        run_instr(7'b0100011, 1'b0, 1'b0, 0, 1000);
        run_instr(7'b0100011, 1'b0, 1'b0, 0, T - 1);
        run_instr(7'b0000011, 1'b1, 1'b0, 0, 1000);
        run_instr(7'b0010011, 1'b1, 1'b0, 1000, 0);
        run_instr(7'b0010011, 1'b1, 1'b0, T - 1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL timeout cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        obs_t e;
        exp_q.delete(); obs_q.delete();
        opcode = 7'b0000011; wb_reg = 1'b1; csr_wb = 1'b0;
        e = '0; e.st = ST_FETCH; e.imem_req = 1'b1; e.ir_we = 1'b1;
        cyc(1'b1, 1'b0, e);
        e = '0; e.st = ST_DECODE; cyc(1'b0, 1'b0, e);
        e = '0; e.st = ST_EXEC;   cyc(1'b0, 1'b0, e);
        e = '0; e.st = ST_MEM; e.dmem_req = 1'b1;
        cyc(1'b0, 1'b0, e);
        cyc(1'b0, 1'b0, e);
        @(negedge clk); rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; #1;
        exp_q.push_back(e); obs_q.push_back(sample());
        @(negedge clk); rst = 1'b0; dmem_ack = 1'b1; #1;
        exp_q.push_back(obs_t'(0)); obs_q.push_back(sample());
        run_instr(7'b0010011, 1'b1, 1'b0, 1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rst_mid cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        for (int n = 0; n < 60; n++) begin
            exp_q.delete(); obs_q.delete();
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 10)];
            else                          op = 7'($urandom);
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, T), $urandom_range(0, T));
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random n%0d op%b cyc%0d: got %h want %h", n, op, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

`ifdef CORE_CTRL_PERF_EN
    task automatic test_perf();
        @(negedge clk); rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk); rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        repeat (10) run_instr(7'b0010011, 1'b1, 1'b0, 0, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL perf_seq cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (instret_cnt !== 64'd10) begin
            errors++; $display("FAIL instret: got %0d want 10", instret_cnt);
        end
        checks++;
        if (cycle_cnt !== 64'd41) begin
            errors++; $display("FAIL cycle_cnt: got %0d want 41", cycle_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_load_delay();
        test_illegal();
        test_timeout();
        test_rst_mid();
        test_random();
`ifdef CORE_CTRL_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
